// File: rtl/baud_ctrl.sv
// Runtime-programmable UART baud controller: oversample/bit tick generator with a
// deferred divisor load. Optional resync/mid_tick ports under BAUD_CTRL_RESYNC_EN.
module baud_ctrl #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 1000000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             line_busy,
  output logic [DIV_W-1:0] div_out,
  output logic             os_tick,
  output logic             tick
`ifdef BAUD_CTRL_RESYNC_EN
  ,
  input  logic             resync,
  output logic             mid_tick
`endif
);

  localparam int SUB_W   = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int DEF_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'((DEF_RAW < 1) ? 1 : DEF_RAW);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, pend_q, pend_d, os_cnt_q, os_cnt_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic             os_tick_q, os_tick_d, tick_q, tick_d, err_q, err_d;
  logic             apply, rs_hit;
  logic [DIV_W-1:0] new_div;

`ifdef BAUD_CTRL_RESYNC_EN
  localparam logic [SUB_W-1:0] SUB_MID_PRE = SUB_W'(OVERSAMPLE / 2 - 1);
  logic mid_q, mid_d;
  assign rs_hit   = resync;
  assign mid_tick = mid_q;
`else
  assign rs_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    div_d     = div_q;
    os_cnt_d  = os_cnt_q;
    sub_d     = sub_q;
    os_tick_d = 1'b0;
    tick_d    = 1'b0;
    err_d     = 1'b0;
    apply     = 1'b0;
    new_div   = cfg_div;
`ifdef BAUD_CTRL_RESYNC_EN
    mid_d     = 1'b0;
`endif

    case (state_q)
      S_RUN: begin
        if (cfg_valid) begin
          if (cfg_div == '0) begin
            err_d = 1'b1;
          end else if (!line_busy) begin
            apply = 1'b1;
          end else begin
            pend_d  = cfg_div;
            state_d = S_PEND;
          end
        end
      end
      default: begin
        // Pending load waits for an idle line, independent of en.
        if (!line_busy) begin
          apply   = 1'b1;
          new_div = pend_q;
          state_d = S_RUN;
        end
      end
    endcase

    if (apply) begin
      div_d    = new_div;
      os_cnt_d = '0;
      sub_d    = '0;
    end else if (!en || rs_hit) begin
      os_cnt_d = '0;
      sub_d    = '0;
    end else if (os_cnt_q == div_q - 1'b1) begin
      os_cnt_d  = '0;
      os_tick_d = 1'b1;
`ifdef BAUD_CTRL_RESYNC_EN
      mid_d     = (sub_q == SUB_MID_PRE);
`endif
      if (sub_q == SUB_LAST) begin
        sub_d  = '0;
        tick_d = 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end else begin
      os_cnt_d = os_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RUN;
      pend_q    <= '0;
      div_q     <= DEF_DIV;
      os_cnt_q  <= '0;
      sub_q     <= '0;
      os_tick_q <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      div_q     <= div_d;
      os_cnt_q  <= os_cnt_d;
      sub_q     <= sub_d;
      os_tick_q <= os_tick_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

`ifdef BAUD_CTRL_RESYNC_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mid_q <= 1'b0;
    else       mid_q <= mid_d;
  end
`endif

  assign cfg_ready = (state_q == S_RUN);
  assign cfg_err   = err_q;
  assign div_out   = div_q;
  assign os_tick   = os_tick_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_baud_ctrl.sv
// Directed bench for baud_ctrl: default rates, immediate/deferred divisor loads,
// zero-divisor rejection, divisor 1, enable gating and reset while pending.
module tb_baud_ctrl;
  logic        clk = 1'b0;
  logic        reset, en, cfg_valid, line_busy;
  logic [15:0] cfg_div;
  logic        cfg_ready, cfg_err, os_tick, tick;
  logic [15:0] div_out;

  int tests = 0;
  int fails = 0;
  int viol  = 0;
  int nos, ntk, fos, ftk;

  baud_ctrl dut (
    .clk(clk), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .line_busy(line_busy),
    .div_out(div_out), .os_tick(os_tick), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, sampling outputs on each following falling edge.
  task automatic run(input int n);
    nos = 0; ntk = 0; fos = 0; ftk = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (os_tick) begin nos++; if (fos == 0) fos = i; end
      if (tick)    begin ntk++; if (ftk == 0) ftk = i; end
      if (tick && !os_tick) viol++;
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; line_busy = 1'b0; cfg_div = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_div", div_out, 3);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_ticks", {cfg_err, os_tick, tick}, 0);

    // defaults
    reset = 1'b0; en = 1'b1;
    run(48);
    chk("def_first_os", fos, 3);
    chk("def_nos", nos, 16);
    chk("def_first_tick", ftk, 48);
    run(48);
    chk("def_nos2", nos, 16);
    chk("def_tick2", ftk, 48);
    chk("def_ntk2", ntk, 1);

    // deferred load while the line is busy
    line_busy = 1'b1; cfg_valid = 1'b1; cfg_div = 16'd7;
    run(1);
    chk("pend_ready", cfg_ready, 0);
    chk("pend_div_old", div_out, 3);
    cfg_div = 16'd9;
    run(9);
    chk("pend_nos", nos, 3);
    chk("pend_first_os", fos, 2);
    chk("pend_ready2", cfg_ready, 0);
    cfg_valid = 1'b0;
    line_busy = 1'b0;
    run(1);
    chk("pend_apply_div", div_out, 7);
    chk("pend_apply_ready", cfg_ready, 1);
    chk("pend_apply_noos", os_tick, 0);
    run(7);
    chk("pend_new_first_os", fos, 7);

    // immediate load
    cfg_valid = 1'b1; cfg_div = 16'd5;
    run(1);
    cfg_valid = 1'b0;
    chk("imm_div", div_out, 5);
    chk("imm_noticks", {os_tick, tick}, 0);
    run(80);
    chk("imm_first_os", fos, 5);
    chk("imm_nos", nos, 16);
    chk("imm_first_tick", ftk, 80);
    chk("imm_ntk", ntk, 1);

    // zero divisor rejected
    cfg_valid = 1'b1; cfg_div = 16'd0;
    run(1);
    cfg_valid = 1'b0;
    chk("err_pulse", cfg_err, 1);
    chk("err_div", div_out, 5);
    chk("err_ready", cfg_ready, 1);
    run(1);
    chk("err_clear", cfg_err, 0);

    // divisor 1
    cfg_valid = 1'b1; cfg_div = 16'd1;
    run(1);
    cfg_valid = 1'b0;
    chk("one_div", div_out, 1);
    run(32);
    chk("one_nos", nos, 32);
    chk("one_ntk", ntk, 2);
    chk("one_first_tick", ftk, 16);

    // enable gating
    cfg_valid = 1'b1; cfg_div = 16'd3;
    run(1);
    cfg_valid = 1'b0;
    run(4);
    en = 1'b0;
    run(10);
    chk("en_off_nos", nos, 0);
    chk("en_off_ntk", ntk, 0);
    en = 1'b1;
    run(3);
    chk("en_on_first_os", fos, 3);

    // reset while pending
    line_busy = 1'b1; cfg_valid = 1'b1; cfg_div = 16'd7;
    run(1);
    cfg_valid = 1'b0;
    chk("rp_ready", cfg_ready, 0);
    reset = 1'b1;
    #1;
    chk("rp_div", div_out, 3);
    chk("rp_ready_rst", cfg_ready, 1);
    chk("rp_outs", {cfg_err, os_tick, tick}, 0);
    line_busy = 1'b0;
    run(2);
    reset = 1'b0;
    run(12);
    chk("rp_div_after", div_out, 3);
    chk("rp_nos", nos, 4);
    chk("rp_first_os", fos, 3);
    chk("rp_ready_after", cfg_ready, 1);

    chk("tick_with_os", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
